// File: rtl/answer_checker.sv
// answer_checker
// Reads the decrypted message out of the answer RAM once decryption has
// finished and checks that every byte is a lowercase letter or a space.
// The first illegal byte ends the check early and is reported together
// with its address. Each failed check advances the brute-force candidate
// key; a failure with the key already at its maximum latches `exhausted`,
// after which further `start` requests are ignored until reset.
//
// Each byte takes three cycles (ADDR, WAIT, CHECK) so that read data is
// stable for up to two cycles after the address changes before sampling.

module answer_checker #(
    parameter int RAM_WIDTH          = 8,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5,
    parameter int KEY_WIDTH          = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [RAM_WIDTH-1:0]          aOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] aAddr,
    output logic                          finished,
    output logic                          pass,
    output logic [MESSAGE_LOG_LENGTH-1:0] failAddr,
    output logic [RAM_WIDTH-1:0]          failChar,
    output logic [KEY_WIDTH-1:0]          key,
    output logic                          exhausted
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_IDX = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
    localparam logic [KEY_WIDTH-1:0]          KEY_MAX  = '1;

    localparam logic [RAM_WIDTH-1:0] CHAR_SPACE = RAM_WIDTH'(8'h20);
    localparam logic [RAM_WIDTH-1:0] CHAR_LOW_A = RAM_WIDTH'(8'h61);
    localparam logic [RAM_WIDTH-1:0] CHAR_LOW_Z = RAM_WIDTH'(8'h7A);

    state_t                          state;
    logic [MESSAGE_LOG_LENGTH-1:0]   idx;
    logic                            byte_ok;

    // A byte is acceptable plaintext if it is a space or a lowercase letter.
    function automatic logic is_legal(input logic [RAM_WIDTH-1:0] c);
        return (c == CHAR_SPACE) || ((c >= CHAR_LOW_A) && (c <= CHAR_LOW_Z));
    endfunction

    // The read address is the byte index itself; no separate address register.
    assign aAddr = idx;

    // Legality of the byte currently presented by the answer RAM.
    always_comb begin
        byte_ok = is_legal(aOut);
    end

    // Check sequencer, result registers and candidate key counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            finished  <= 1'b0;
            pass      <= 1'b0;
            failAddr  <= '0;
            failChar  <= '0;
            key       <= '0;
            exhausted <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= ADDR;
                    end
                end

                ADDR: begin
                    state <= WAIT;
                end

                WAIT: begin
                    state <= CHECK;
                end

                CHECK: begin
                    if (byte_ok) begin
                        if (idx == LAST_IDX) begin
                            // Whole message accepted; the key is the answer.
                            state    <= DONE;
                            finished <= 1'b1;
                            pass     <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ADDR;
                        end
                    end else begin
                        // First bad byte ends the check; remaining bytes are skipped.
                        state    <= DONE;
                        finished <= 1'b1;
                        pass     <= 1'b0;
                        failAddr <= idx;
                        failChar <= aOut;
                        if (key == KEY_MAX) begin
                            exhausted <= 1'b1;
                        end else begin
                            key <= key + 1'b1;
                        end
                    end
                end

                DONE: begin
                    // Once the key space is used up only reset leaves DONE.
                    if (start && !exhausted) begin
                        idx      <= '0;
                        state    <= ADDR;
                        finished <= 1'b0;
                        pass     <= 1'b0;
                        failAddr <= '0;
                        failChar <= '0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/answer_checker.md
# answer_checker

Reads the decrypted message out of the answer RAM after the decryptor asserts `finished`. It checks that every byte is a lowercase ASCII letter or a space, and reports pass or fail with the first offending address and byte. It also owns the brute-force key counter: each failed check advances the candidate key, so the top-level controller can re-run key scheduling and decryption with the next key.

## Interface
Parameters:
- `RAM_WIDTH`, 8, answer-RAM data width.
- `MESSAGE_LENGTH`, 32, number of bytes checked.
- `MESSAGE_LOG_LENGTH`, 5, address width of the answer RAM.
- `KEY_WIDTH`, 24, candidate key counter width.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: reset is asynchronous and active-high.
- `start` in 1: begin a check; sampled on the rising edge in IDLE or DONE.
- `aOut` in `RAM_WIDTH`: answer-RAM read data; valid no later than 2 cycles after `aAddr` changes.
- `aAddr` out `MESSAGE_LOG_LENGTH`: answer-RAM read address (answer RAM write enable is never driven here).
- `finished` out 1: check complete; results valid.
- `pass` out 1: all bytes legal.
- `failAddr` out `MESSAGE_LOG_LENGTH`: index of first illegal byte.
- `failChar` out `RAM_WIDTH`: value of first illegal byte.
- `key` out `KEY_WIDTH`: current candidate key.
- `exhausted` out 1: a fail occurred with `key` already at its maximum, 2^`KEY_WIDTH`−1.

## Operation
- States: IDLE, ADDR, WAIT, CHECK, DONE. There is an internal index `idx` of width `MESSAGE_LOG_LENGTH`, and `aAddr` = `idx` at all times.
- IDLE:
  - `start`=1 → ADDR with `idx`=0.
  - Otherwise stay in IDLE.
- ADDR → WAIT → CHECK unconditionally, one cycle each.
- CHECK samples `aOut`:
  - A byte is legal iff it is 8'h20, or in 8'h61..8'h7A inclusive.
  - Legal and `idx` < `MESSAGE_LENGTH`−1 → `idx`+1, then ADDR.
  - Legal and `idx` = `MESSAGE_LENGTH`−1 → DONE; `pass`←1; `key` unchanged.
  - Illegal → DONE:
    - `pass`←0, `failAddr`←`idx`, `failChar`←`aOut`.
    - If `key` < max, `key`←`key`+1.
    - If `key` = max, `key` holds and `exhausted`←1.
- DONE:
  - `finished`=1.
  - `start`=1 and `exhausted`=0 → ADDR with `idx`=0; `finished`, `pass`, `failAddr` and `failChar` clear on that edge.
  - `start`=1 with `exhausted`=1 is ignored; only `reset` leaves this condition.
- `start` in ADDR, WAIT or CHECK is ignored; no restart and no queuing.
- `finished` is a registered state decode: high only in DONE.
- `key` is never cleared by `start`, only by `reset`.

## Timing
- Reset values: state IDLE, `idx`=0, `aAddr`=0, `finished`=0, `pass`=0, `failAddr`=0, `failChar`=0, `key`=0, `exhausted`=0.
- Reset asserted mid-check: all of the above take effect immediately (asynchronous). The in-progress check is discarded and no key increment occurs.
- Count edges from the edge that samples `start` (edge 0). Byte n occupies:
  - ADDR during edges 3n..3n+1.
  - WAIT during edges 3n+1..3n+2.
  - CHECK during edges 3n+2..3n+3.
- Full pass: `finished` rises at edge 3·`MESSAGE_LENGTH` (96 with defaults).
- Fail at index f: `finished` rises at edge 3(f+1). `key` and the fail fields update on that same edge.
- Early abort: bytes after the first illegal one are never read.
- Address arithmetic: `idx` never wraps within a check; the last address read is `MESSAGE_LENGTH`−1.

## Test plan
- Reset:
  - Stimulus: assert `reset`, release.
  - Required: all outputs 0, state IDLE, `aAddr`=0.
  - With `start` low, outputs stay unchanged.
- All-legal message:
  - Stimulus: RAM holds 32 bytes of "the quick brown fox jumps over a"; pulse `start`.
  - Required: `finished`=1 at edge 96, `pass`=1, `key`=0.
  - The `aAddr` sequence is 0..31, each address held 3 cycles.
- Mid-message fail:
  - Stimulus: byte 5 = 8'h41; pulse `start`.
  - Required: `finished` at edge 18, `pass`=0, `failAddr`=5, `failChar`=8'h41, `key`=1.
  - `aAddr` never exceeds 5.
- Character boundaries:
  - Stimulus: index 0 set in turn to 8'h60, 8'h7B, 8'h1F, 8'h21, 8'hFF; then index 31 = 8'h7B with the rest legal (8'h61, 8'h7A, 8'h20 included).
  - Required: index-0 values each fail at edge 3 with `failAddr`=0.
  - Required: the index-31 case fails at edge 96 with `failAddr`=31.
- Key exhaustion:
  - Stimulus: `KEY_WIDTH`=2, message always illegal, `start` issued 4 times from DONE.
  - Required: `key` steps 1, 2, 3, then holds 3 with `exhausted`=1.
  - Required: a fifth `start` leaves the block in DONE with `aAddr` unchanged.
- Reset and busy start:
  - Stimulus: `start` pulsed again at edge 10 of a legal check.
  - Required: ignored; `finished` still rises at edge 96.
  - Stimulus: `reset` asserted asynchronously at edge 40 of a later check.
  - Required: immediate IDLE, `finished`=0, `key`=0, `aAddr`=0.
